// File: rtl/inv_sbox_layer.sv
// inv_sbox_layer: nibble-serial inverse PRESENT S-box over a state word, IDLE/BUSY/DONE handshake
module inv_sbox_layer #(
  parameter int NIBBLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   r,
  output logic                   busy
);
  localparam int CW = $clog2(NIBBLES);
  localparam logic [63:0] INV = 64'hA970364BD21C8FE5;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [4*NIBBLES-1:0]   st;
  logic [3:0]             nib;
  assign nib       = st[4*cnt +: 4];
  assign in_ready  = state == IDLE;
  assign busy      = state == BUSY;
  assign out_valid = state == DONE;
  assign r         = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st    <= x;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          st[4*cnt +: 4] <= INV[4*nib +: 4];
          cnt            <= (cnt == LAST) ? '0 : cnt + CW'(1);
          state          <= (cnt == LAST) ? DONE : BUSY;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sbox_layer.sv
// tb_inv_sbox_layer: directed-vector bench for inv_sbox_layer (16- and 2-nibble instances)
module tb_inv_sbox_layer;
  logic        clk = 0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [63:0] x;
  logic        in_ready, out_valid, busy;
  logic [63:0] r;
  logic        in_valid2, out_ready2;
  logic [7:0]  x2;
  logic        in_ready2, out_valid2, busy2;
  logic [7:0]  r2;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  inv_sbox_layer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .busy(busy)
  );
  inv_sbox_layer #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
    .out_valid(out_valid2), .out_ready(out_ready2), .r(r2), .busy(busy2)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [63:0] xv, input logic [63:0] exp);
    int n;
    check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    in_valid = 1;
    x = xv;
    tick();
    in_valid = 0;
    x = 64'hDEAD_BEEF_0000_FFFF;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd16);
    check({tag, " r"}, r, exp);
  endtask
  initial begin
    rst = 1; in_valid = 0; out_ready = 1; x = '0;
    in_valid2 = 0; out_ready2 = 1; x2 = '0;
    tick();
    tick();
    rst = 0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset r", r, 64'd0);
    run("zero", 64'h0, 64'h5555555555555555);
    tick();
    check("zero back idle", 64'(in_ready), 64'd1);
    check("zero out_valid low", 64'(out_valid), 64'd0);
    run("count", 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
    tick();
    run("roundtrip", 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
    tick();
    out_ready = 0;
    run("hold", 64'hFFFFFFFF00000000, 64'hAAAAAAAA55555555);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x = {32'h0, 32'(i)};
      tick();
      check("hold r", r, 64'hAAAAAAAA55555555);
      check("hold out_valid", 64'(out_valid), 64'd1);
      check("hold in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("release in_ready", 64'(in_ready), 64'd1);
    check("release out_valid", 64'(out_valid), 64'd0);
    tick();
    check("stay idle", 64'(in_ready), 64'd1);
    check("stay idle busy", 64'(busy), 64'd0);
    in_valid = 1;
    x = 64'h0123456789ABCDEF;
    tick();
    in_valid = 0;
    for (int i = 0; i < 7; i++) tick();
    check("mid busy", 64'(busy), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort r", r, 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort no out_valid", 64'(out_valid), 64'd0);
    end
    run("after abort", 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
    tick();
    check("n2 in_ready", 64'(in_ready2), 64'd1);
    in_valid2 = 1;
    x2 = 8'hFE;
    tick();
    in_valid2 = 0;
    check("n2 busy", 64'(busy2), 64'd1);
    tick();
    check("n2 not yet", 64'(out_valid2), 64'd0);
    tick();
    check("n2 out_valid", 64'(out_valid2), 64'd1);
    check("n2 r", 64'(r2), 64'hA9);
    tick();
    check("n2 back idle", 64'(in_ready2), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
